// File: rtl/lcd_char_frame_driver.sv
// lcd_char_frame_driver
//   HD44780-class 16x2 character LCD driver for the watch. Runs the power-up
//   init sequence once, then refreshes line 1 with "HH:MM:SS" and line 2 with
//   "YY-MM-DD" forever. Every LCD write is one step: RS/DATA are presented at
//   step entry, LCD_E is high for E_HIGH cycles starting one cycle later, and
//   RS/DATA stay stable until the step ends, which gives setup and hold time.
//   One digit can be blanked on alternate blink phases for the set mode.
//   There is no valid/ready handshake here: the LCD is write-only and paced
//   purely by the step timers, so inputs are simply sampled once per frame.
module lcd_char_frame_driver #(
  parameter int PWRUP_CYCLES = 70,
  parameter int STEP_CYCLES  = 20,
  parameter int E_HIGH       = 4,
  parameter int CLR_CYCLES   = 200,
  parameter int BLINK_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [23:0] TIME_BCD,
  input  logic [23:0] DATE_BCD,
  input  logic        BLINK_EN,
  input  logic [3:0]  BLINK_POS,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic [7:0]  LCD_DATA,
  output logic        INIT_DONE,
  output logic        FRAME_DONE,
  output logic [3:0]  DBG_STATE
);

  // Step/blink counters are wide enough for any practical cycle parameter.
  localparam int CW = 16;

  typedef enum logic [3:0] {
    ST_PWRUP = 4'd0,
    ST_FUNC  = 4'd1,
    ST_DISP  = 4'd2,
    ST_ENTRY = 4'd3,
    ST_CLEAR = 4'd4,
    ST_ADDR1 = 4'd5,
    ST_L1    = 4'd6,
    ST_ADDR2 = 4'd7,
    ST_L2    = 4'd8
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] step_len;
  logic          step_end;
  logic [3:0]    char_idx;
  logic          frame_end;
  logic          e_window;

  logic          init_done_q;
  logic [23:0]   snap_time;
  logic [23:0]   snap_date;
  logic          snap_blink_en;
  logic [3:0]    snap_blink_pos;
  logic [CW-1:0] blink_cnt;
  logic          blink_off;

  logic          is_line2;
  logic          is_digit;
  logic [2:0]    dig_sel;
  logic [3:0]    digit_idx;
  logic [3:0]    nib;
  logic [23:0]   src;
  logic [7:0]    char_byte;

  // BCD digit to ASCII; anything outside 0..9 shows as '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) c = {4'h3, d};
    else           c = 8'h3F;
    return c;
  endfunction

  // Nibble sel (0 = most significant) of a six-digit BCD bus.
  function automatic logic [3:0] nibble_at(input logic [23:0] bus, input logic [2:0] sel);
    logic [3:0] n;
    case (sel)
      3'd0:    n = bus[23:20];
      3'd1:    n = bus[19:16];
      3'd2:    n = bus[15:12];
      3'd3:    n = bus[11:8];
      3'd4:    n = bus[7:4];
      default: n = bus[3:0];
    endcase
    return n;
  endfunction

  // Length of the current step and its last cycle.
  always_comb begin
    case (state)
      ST_PWRUP: step_len = CW'(PWRUP_CYCLES);
      ST_CLEAR: step_len = CW'(CLR_CYCLES);
      default:  step_len = CW'(STEP_CYCLES);
    endcase
    step_end  = (cnt == step_len - CW'(1));
    frame_end = (state == ST_L2) && (char_idx == 4'd15) && step_end;
    e_window  = (cnt >= CW'(1)) && (cnt <= CW'(E_HIGH));
  end

  // Next-state: advance one command/character per completed step.
  always_comb begin
    state_next = state;
    if (step_end) begin
      case (state)
        ST_PWRUP: state_next = ST_FUNC;
        ST_FUNC:  state_next = ST_DISP;
        ST_DISP:  state_next = ST_ENTRY;
        ST_ENTRY: state_next = ST_CLEAR;
        ST_CLEAR: state_next = ST_ADDR1;
        ST_ADDR1: state_next = ST_L1;
        ST_L1:    state_next = (char_idx == 4'd15) ? ST_ADDR2 : ST_L1;
        ST_ADDR2: state_next = ST_L2;
        ST_L2:    state_next = (char_idx == 4'd15) ? ST_ADDR1 : ST_L2;
        default:  state_next = ST_PWRUP;
      endcase
    end
  end

  // State register, step cycle counter and character column.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state    <= ST_PWRUP;
      cnt      <= '0;
      char_idx <= '0;
    end else begin
      state <= state_next;
      cnt   <= step_end ? '0 : cnt + CW'(1);
      // 16 columns in a 4-bit index wrap back to 0 exactly at line end.
      if (step_end && ((state == ST_L1) || (state == ST_L2)))
        char_idx <= char_idx + 4'd1;
    end
  end

  // INIT_DONE is set on entry to ADDR1 (so it is high at k=0) and the frame
  // inputs are frozen at the end of ADDR1 k=0 for the rest of the frame.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      init_done_q    <= 1'b0;
      snap_time      <= '0;
      snap_date      <= '0;
      snap_blink_en  <= 1'b0;
      snap_blink_pos <= '0;
    end else begin
      if ((state_next == ST_ADDR1) && (state != ST_ADDR1))
        init_done_q <= 1'b1;
      if ((state == ST_ADDR1) && (cnt == '0)) begin
        snap_time      <= TIME_BCD;
        snap_date      <= DATE_BCD;
        snap_blink_en  <= BLINK_EN;
        snap_blink_pos <= BLINK_POS;
      end
    end
  end

  // Blink phase: toggles every BLINK_FRAMES completed frames, starts "on".
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  // Character for the current column. BLINK_POS is a digit index
  // (0..5 time, 6..11 date, MSB first), not a screen column.
  always_comb begin
    is_line2  = (state == ST_L2);
    src       = is_line2 ? snap_date : snap_time;
    dig_sel   = 3'd0;
    is_digit  = 1'b0;
    char_byte = 8'h20;
    case (char_idx)
      4'd0:       begin dig_sel = 3'd0; is_digit = 1'b1; end
      4'd1:       begin dig_sel = 3'd1; is_digit = 1'b1; end
      4'd3:       begin dig_sel = 3'd2; is_digit = 1'b1; end
      4'd4:       begin dig_sel = 3'd3; is_digit = 1'b1; end
      4'd6:       begin dig_sel = 3'd4; is_digit = 1'b1; end
      4'd7:       begin dig_sel = 3'd5; is_digit = 1'b1; end
      4'd2, 4'd5: char_byte = is_line2 ? 8'h2D : 8'h3A;
      default:    char_byte = 8'h20;
    endcase
    digit_idx = {1'b0, dig_sel} + (is_line2 ? 4'd6 : 4'd0);
    nib       = nibble_at(src, dig_sel);
    if (is_digit) begin
      if (snap_blink_en && blink_off && (snap_blink_pos <= 4'd11) &&
          (snap_blink_pos == digit_idx))
        char_byte = 8'h20;
      else
        char_byte = digit_char(nib);
    end
  end

  // LCD pins: byte and RS from step entry, E strobe inside the step.
  always_comb begin
    LCD_E      = 1'b0;
    LCD_RS     = 1'b0;
    LCD_DATA   = 8'h00;
    FRAME_DONE = 1'b0;
    case (state)
      ST_PWRUP: LCD_DATA = 8'h00;
      ST_FUNC:  begin LCD_DATA = 8'h38; LCD_E = e_window; end
      ST_DISP:  begin LCD_DATA = 8'h0C; LCD_E = e_window; end
      ST_ENTRY: begin LCD_DATA = 8'h06; LCD_E = e_window; end
      ST_CLEAR: begin LCD_DATA = 8'h01; LCD_E = e_window; end
      ST_ADDR1: begin LCD_DATA = 8'h80; LCD_E = e_window; end
      ST_ADDR2: begin LCD_DATA = 8'hC0; LCD_E = e_window; end
      ST_L1:    begin LCD_DATA = char_byte; LCD_RS = 1'b1; LCD_E = e_window; end
      ST_L2:    begin
        LCD_DATA   = char_byte;
        LCD_RS     = 1'b1;
        LCD_E      = e_window;
        FRAME_DONE = frame_end;
      end
      default:  LCD_DATA = 8'h00;
    endcase
  end

  assign LCD_RW    = 1'b0;
  assign INIT_DONE = init_done_q;
  assign DBG_STATE = state;

endmodule
